fpu_sequencer: RTL and testbench
================================

# fpu_sequencer

Issue controller between the EX stage and the single-precision `fpu`.
- Accepts one FP op at a time and holds its operands, func and rounding mode stable until the `fpu` finishes; the `fpu` detects new work by input change and stays busy for several cycles.
- Captures the result and returns it through a valid/ready port.
- Owns the 24x24 integer multiplier that `fpu` FMULS shares with integer MUL, and arbitrates it.

## Interface
- `MAX_WAIT`, 32: WAIT-state watchdog limit in cycles; the counter is 6 bits wide.
- `clk` in 1: the only clock.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: an FP op is presented.
- `req_func` in 5: `ALU_*` code from `sys_defs.vh`.
- `req_opa`, `req_opb` in 32 each: operands.
- `req_rm` in 3: rounding mode.
- `req_ready` out 1: the request is accepted on `req_valid && req_ready`.
- `fpu_opa`, `fpu_opb` out 32 each; `fpu_func` out 5; `fpu_rm` out 3: drive the `fpu`.
- `fpu_busy` in 1; `fpu_res` in 32: from the `fpu`.
- `resp_valid` out 1; `resp_data` out 32; `resp_ready` in 1: result port.
- `timeout` out 1: one-cycle pulse when the watchdog fires.
- `mul_req_int` in 1: integer MUL requests the multiplier.
- `mul_grant_int` out 1; `mul_grant_fpu` out 1: registered grants, mutually exclusive.

## Operation
- FSM states: IDLE, LAUNCH, WAIT, RESP.
- Multi-cycle class is FMULS, FADDS, FSUBS. Every other func (FCVT*) is single-cycle.
- IDLE
  - Drives `fpu_opa`=`fpu_opb`=0, `fpu_func`=`ALU_ADD`, `fpu_rm`=0. This neutral value guarantees that every launched FP func differs from the previous input, so the `fpu` sees a new input even for back-to-back identical ops.
  - `req_ready`=1 unless the request is FMULS and the multiplier is not grantable this cycle (see arbitration).
  - On accept: latch op, operands and rm; go to LAUNCH.
- LAUNCH
  - Drives the latched values; `fpu_busy` is ignored in this cycle.
  - Single-cycle op: `resp_data`<=`fpu_res`, go to RESP.
  - Multi-cycle op: clear the watchdog, go to WAIT.
- WAIT
  - Keeps driving the latched values. The watchdog increments each cycle.
  - When `fpu_busy`==0: `resp_data`<=`fpu_res`, go to RESP.
  - When the watchdog reaches `MAX_WAIT`: pulse `timeout`, capture `fpu_res` anyway, go to RESP.
- RESP
  - `resp_valid`=1 and `resp_data` are held until `resp_ready`, then go to IDLE.
  - `fpu_*` outputs keep the latched values (no new-input event).
  - Returning to IDLE also drops `mul_grant_fpu`.
- Multiplier arbitration; owner is one of NONE, INT, FPU.
  - NONE and `mul_req_int`: grant INT next cycle.
  - NONE and FMULS accepted: grant FPU next cycle, i.e. asserted from LAUNCH onward.
  - If both are requested in the same NONE cycle, INT wins when the last owner was FPU, and FPU wins otherwise (alternating priority); the loser waits with `req_ready`=0.
  - INT keeps the grant while `mul_req_int`=1; FPU keeps it until the FSM re-enters IDLE.
  - FMULS is refused (`req_ready`=0) while the owner is INT.
- Reset values: FSM IDLE, owner NONE, last owner INT, all grants 0, `req_ready`=1, `resp_valid`=0, `resp_data`=0, `timeout`=0, `fpu_*` neutral.
- A reset mid-operation discards the op; no response is produced. The `fpu` shares `rst` and resets in the same cycle.

## Timing
- Accept at cycle t, then LAUNCH at t+1.
  - Single-cycle op: `resp_valid` at t+2.
  - Multi-cycle op: `resp_valid` one cycle after the first WAIT cycle with `fpu_busy`=0, so minimum t+3.
- The throughput limit is one op in flight. The next accept is possible in the cycle after the response handshake.
- `req_ready` is combinational from state, owner, `req_func` and `mul_req_int`. All other outputs are registered.

## Structure
- `fpu_seq_pkg`:
  - state enum.
  - owner enum.
  - `is_multicycle(func)` function built on the `sys_defs.vh` `ALU_*` codes.
  - neutral-input constants.
- Sub-module `mul_arbiter`: owner and last-owner registers, grant outputs, and a combinational `fpu_grantable` output.

## Test plan
- FADDS 0x3F800000 + 0x40000000, `fpu_busy` high for 3 cycles after LAUNCH -> `resp_data`=0x40400000; `fpu_*` stable through WAIT.
- Two back-to-back identical FMULS 0x40000000*0x40400000 -> the `fpu` reports busy for both; both responses are 0x40C00000.
- FCVTSW opa=5 -> `resp_valid` exactly 2 cycles after accept, `resp_data`=0x40A00000.
- `mul_req_int`=1 held, FMULS requested -> `req_ready`=0 until `mul_req_int` drops; then `mul_grant_fpu`=1 from LAUNCH until IDLE; the two grants are never high together.
- `fpu_busy` stuck high -> `timeout` pulses after `MAX_WAIT`, then RESP; `resp_ready`=0 for 4 cycles -> `resp_valid` and `resp_data` held.
- `rst` asserted in WAIT -> next cycle IDLE, grants 0, `resp_valid`=0, `fpu_func`=`ALU_ADD`.

Source files
------------

// File: rtl/fpu_seq_pkg.sv
// Shared types, ALU function codes and neutral FPU input values for the FPU issue sequencer.
// Neutral inputs differ from every FP func, so each launch looks like fresh work to the fpu.
package fpu_seq_pkg;

  localparam logic [4:0] ALU_ADD    = 5'd0;
  localparam logic [4:0] ALU_FADDS  = 5'd16;
  localparam logic [4:0] ALU_FSUBS  = 5'd17;
  localparam logic [4:0] ALU_FMULS  = 5'd18;
  localparam logic [4:0] ALU_FCVTSW = 5'd19;

  localparam logic [31:0] NEUTRAL_OP   = 32'd0;
  localparam logic [4:0]  NEUTRAL_FUNC = ALU_ADD;
  localparam logic [2:0]  NEUTRAL_RM   = 3'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_RESP
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_INT,
    OWN_FPU
  } owner_t;

  function automatic logic is_multicycle(input logic [4:0] func);
    return (func == ALU_FMULS) || (func == ALU_FADDS) || (func == ALU_FSUBS);
  endfunction

endpackage

// File: rtl/mul_arbiter.sv
// Arbitrates the shared 24x24 multiplier between integer MUL and FMULS; grants are registered.
// INT holds while requesting, FPU holds until released; ties alternate based on the last owner.
module mul_arbiter
  import fpu_seq_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic mul_req_int,
  input  logic fpu_take,
  input  logic fpu_release,
  output logic mul_grant_int,
  output logic mul_grant_fpu,
  output logic fpu_grantable
);

  owner_t owner, owner_nxt;
  owner_t last_owner, last_nxt;

  // FPU may only take a free multiplier, and loses a tie if it was the previous owner.
  assign fpu_grantable = (owner == OWN_NONE) && !(mul_req_int && (last_owner == OWN_FPU));

  always_comb begin
    owner_nxt = owner;
    last_nxt  = last_owner;
    case (owner)
      OWN_NONE: begin
        if (fpu_take) begin
          owner_nxt = OWN_FPU;
          last_nxt  = OWN_FPU;
        end else if (mul_req_int) begin
          owner_nxt = OWN_INT;
          last_nxt  = OWN_INT;
        end
      end
      OWN_INT: if (!mul_req_int) owner_nxt = OWN_NONE;
      OWN_FPU: if (fpu_release) owner_nxt = OWN_NONE;
      default: owner_nxt = OWN_NONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner         <= OWN_NONE;
      last_owner    <= OWN_INT;
      mul_grant_int <= 1'b0;
      mul_grant_fpu <= 1'b0;
    end else begin
      owner         <= owner_nxt;
      last_owner    <= last_nxt;
      mul_grant_int <= (owner_nxt == OWN_INT);
      mul_grant_fpu <= (owner_nxt == OWN_FPU);
    end
  end

endmodule

// File: rtl/fpu_sequencer.sv
// Issues one FP op at a time to the fpu and returns its result on a valid/ready port.
// Single-cycle ops respond 2 cycles after accept, multi-cycle ops at least 3; req_ready low while busy.
module fpu_sequencer
  import fpu_seq_pkg::*;
#(
  parameter int MAX_WAIT = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [4:0]  req_func,
  input  logic [31:0] req_opa,
  input  logic [31:0] req_opb,
  input  logic [2:0]  req_rm,
  output logic        req_ready,
  output logic [31:0] fpu_opa,
  output logic [31:0] fpu_opb,
  output logic [4:0]  fpu_func,
  output logic [2:0]  fpu_rm,
  input  logic        fpu_busy,
  input  logic [31:0] fpu_res,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  input  logic        resp_ready,
  output logic        timeout,
  input  logic        mul_req_int,
  output logic        mul_grant_int,
  output logic        mul_grant_fpu
);

  localparam logic [5:0] WD_LIMIT = 6'(MAX_WAIT);

  state_t     state, state_nxt;
  logic [5:0] wd_cnt;
  logic       fpu_grantable;
  logic       accept;
  logic       take_mul;
  logic       release_mul;
  logic       wd_fire;
  logic       multi;

  assign req_ready   = (state == ST_IDLE) && ((req_func != ALU_FMULS) || fpu_grantable);
  assign accept      = req_valid && req_ready;
  assign take_mul    = accept && (req_func == ALU_FMULS);
  assign release_mul = (state == ST_RESP) && resp_ready;
  assign wd_fire     = (wd_cnt == WD_LIMIT);
  assign multi       = is_multicycle(fpu_func);

  mul_arbiter u_mul_arbiter (
    .clk           (clk),
    .rst           (rst),
    .mul_req_int   (mul_req_int),
    .fpu_take      (take_mul),
    .fpu_release   (release_mul),
    .mul_grant_int (mul_grant_int),
    .mul_grant_fpu (mul_grant_fpu),
    .fpu_grantable (fpu_grantable)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (accept) state_nxt = ST_LAUNCH;
      ST_LAUNCH: state_nxt = multi ? ST_WAIT : ST_RESP;
      ST_WAIT:   if (!fpu_busy || wd_fire) state_nxt = ST_RESP;
      ST_RESP:   if (resp_ready) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // The fpu_* registers double as the op latch; they return to neutral only on leaving RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      fpu_opa    <= NEUTRAL_OP;
      fpu_opb    <= NEUTRAL_OP;
      fpu_func   <= NEUTRAL_FUNC;
      fpu_rm     <= NEUTRAL_RM;
      resp_valid <= 1'b0;
      resp_data  <= 32'd0;
      timeout    <= 1'b0;
      wd_cnt     <= 6'd0;
    end else begin
      timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            fpu_opa  <= req_opa;
            fpu_opb  <= req_opb;
            fpu_func <= req_func;
            fpu_rm   <= req_rm;
          end
        end
        ST_LAUNCH: begin
          wd_cnt <= 6'd0;
          if (!multi) begin
            resp_data  <= fpu_res;
            resp_valid <= 1'b1;
          end
        end
        ST_WAIT: begin
          wd_cnt <= wd_cnt + 6'd1;
          if (!fpu_busy || wd_fire) begin
            resp_data  <= fpu_res;
            resp_valid <= 1'b1;
            timeout    <= fpu_busy;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            fpu_opa    <= NEUTRAL_OP;
            fpu_opb    <= NEUTRAL_OP;
            fpu_func   <= NEUTRAL_FUNC;
            fpu_rm     <= NEUTRAL_RM;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_sequencer.sv
// Directed bench for fpu_sequencer with a small change-detecting fpu model and a result lookup.
module tb_fpu_sequencer;
  import fpu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [4:0]  req_func;
  logic [31:0] req_opa;
  logic [31:0] req_opb;
  logic [2:0]  req_rm;
  logic        req_ready;
  logic [31:0] fpu_opa;
  logic [31:0] fpu_opb;
  logic [4:0]  fpu_func;
  logic [2:0]  fpu_rm;
  logic        fpu_busy;
  logic [31:0] fpu_res;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_ready;
  logic        timeout;
  logic        mul_req_int;
  logic        mul_grant_int;
  logic        mul_grant_fpu;

  int n_checks = 0;
  int n_fail   = 0;

  fpu_sequencer #(.MAX_WAIT(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_func      (req_func),
    .req_opa       (req_opa),
    .req_opb       (req_opb),
    .req_rm        (req_rm),
    .req_ready     (req_ready),
    .fpu_opa       (fpu_opa),
    .fpu_opb       (fpu_opb),
    .fpu_func      (fpu_func),
    .fpu_rm        (fpu_rm),
    .fpu_busy      (fpu_busy),
    .fpu_res       (fpu_res),
    .resp_valid    (resp_valid),
    .resp_data     (resp_data),
    .resp_ready    (resp_ready),
    .timeout       (timeout),
    .mul_req_int   (mul_req_int),
    .mul_grant_int (mul_grant_int),
    .mul_grant_fpu (mul_grant_fpu)
  );

  always #5 clk = ~clk;

  // fpu model: busy starts one cycle after its inputs change to an FP multi-cycle func.
  logic [71:0] prev_in;
  logic [2:0]  busy_cnt;
  logic        stuck;

  always @(posedge clk) begin
    if (rst) begin
      busy_cnt <= 3'd0;
      prev_in  <= {NEUTRAL_FUNC, NEUTRAL_RM, NEUTRAL_OP, NEUTRAL_OP};
    end else begin
      prev_in <= {fpu_func, fpu_rm, fpu_opa, fpu_opb};
      if (({fpu_func, fpu_rm, fpu_opa, fpu_opb} != prev_in) &&
          (fpu_func == ALU_FADDS || fpu_func == ALU_FSUBS || fpu_func == ALU_FMULS))
        busy_cnt <= (fpu_func == ALU_FADDS) ? 3'd3 : 3'd2;
      else if (busy_cnt != 3'd0)
        busy_cnt <= busy_cnt - 3'd1;
    end
  end

  assign fpu_busy = stuck || (busy_cnt != 3'd0);

  always_comb begin
    fpu_res = 32'hDEADBEEF;
    if (fpu_func == ALU_FADDS && fpu_opa == 32'h3F800000 && fpu_opb == 32'h40000000) fpu_res = 32'h40400000;
    if (fpu_func == ALU_FSUBS && fpu_opa == 32'h40400000 && fpu_opb == 32'h3F800000) fpu_res = 32'h40000000;
    if (fpu_func == ALU_FMULS && fpu_opa == 32'h40000000 && fpu_opb == 32'h40400000) fpu_res = 32'h40C00000;
    if (fpu_func == ALU_FCVTSW && fpu_opa == 32'd5) fpu_res = 32'h40A00000;
  end

  int both_hi = 0;
  int fpu_grant_cycles = 0;
  always @(negedge clk) begin
    if (mul_grant_int && mul_grant_fpu) both_hi++;
    if (mul_grant_fpu) fpu_grant_cycles++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Called just after a negedge; returns at the negedge where resp_valid is first seen.
  task automatic do_op(input string tag, input logic [4:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] rm, input logic [31:0] exp_d, input int exp_lat, output int waits);
    int n;
    bit stable;
    req_valid = 1'b1;
    req_func  = f;
    req_opa   = a;
    req_opb   = b;
    req_rm    = rm;
    #1;
    waits = 0;
    while (!req_ready && waits < 100) begin
      @(negedge clk);
      #1;
      waits++;
    end
    chk({tag, "_accepted"}, {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    n = 1;
    @(negedge clk);
    req_valid = 1'b0;
    stable = 1'b1;
    while (!resp_valid && n < 100) begin
      if (fpu_func !== f || fpu_opa !== a || fpu_opb !== b || fpu_rm !== rm) stable = 1'b0;
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk({tag, "_latency"}, n, exp_lat);
    chk({tag, "_data"}, resp_data, exp_d);
    chk({tag, "_fpu_in_stable"}, {31'd0, stable}, 32'd1);
  endtask

  initial begin
    int w;
    bit ok;
    rst = 1'b1;
    req_valid = 1'b0;
    req_func = ALU_FADDS;
    req_opa = 32'd0;
    req_opb = 32'd0;
    req_rm = 3'd0;
    resp_ready = 1'b1;
    mul_req_int = 1'b0;
    stuck = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);
    chk("rst_grants", {30'd0, mul_grant_int, mul_grant_fpu}, 32'd0);
    chk("rst_fpu_func", {27'd0, fpu_func}, {27'd0, ALU_ADD});
    chk("rst_fpu_opa", fpu_opa, 32'd0);

    do_op("fadds", ALU_FADDS, 32'h3F800000, 32'h40000000, 3'd0, 32'h40400000, 6, w);
    @(negedge clk);
    chk("fadds_idle_neutral", {27'd0, fpu_func}, {27'd0, ALU_ADD});

    do_op("fmuls1", ALU_FMULS, 32'h40000000, 32'h40400000, 3'd1, 32'h40C00000, 5, w);
    do_op("fmuls2", ALU_FMULS, 32'h40000000, 32'h40400000, 3'd1, 32'h40C00000, 5, w);
    chk("fmuls2_b2b_wait", w, 1);
    @(negedge clk);

    do_op("fcvtsw", ALU_FCVTSW, 32'd5, 32'd0, 3'd0, 32'h40A00000, 2, w);
    @(negedge clk);

    mul_req_int = 1'b1;
    @(negedge clk);
    #1;
    chk("arb_int_grant", {30'd0, mul_grant_int, mul_grant_fpu}, 32'd2);
    fpu_grant_cycles = 0;
    fork
      do_op("arb_fmuls", ALU_FMULS, 32'h40000000, 32'h40400000, 3'd0, 32'h40C00000, 5, w);
      begin
        repeat (4) @(negedge clk);
        mul_req_int = 1'b0;
      end
    join
    chk("arb_fmuls_wait", w, 5);
    @(negedge clk);
    #1;
    chk("arb_fpu_grant_dropped", {31'd0, mul_grant_fpu}, 32'd0);
    chk("arb_fpu_grant_cycles", fpu_grant_cycles, 5);

    stuck = 1'b1;
    resp_ready = 1'b0;
    do_op("tmo", ALU_FSUBS, 32'h40400000, 32'h3F800000, 3'd2, 32'h40000000, 35, w);
    chk("tmo_pulse", {31'd0, timeout}, 32'd1);
    ok = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (!resp_valid || resp_data !== 32'h40000000 || timeout) ok = 1'b0;
    end
    chk("tmo_resp_held", {31'd0, ok}, 32'd1);
    resp_ready = 1'b1;
    stuck = 1'b0;
    @(negedge clk);
    chk("tmo_resp_released", {31'd0, resp_valid}, 32'd0);

    stuck = 1'b1;
    req_valid = 1'b1;
    req_func = ALU_FMULS;
    req_opa = 32'h40000000;
    req_opb = 32'h40400000;
    req_rm = 3'd0;
    #1;
    chk("rstw_accept", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rstw_grant_before", {31'd0, mul_grant_fpu}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("rstw_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rstw_grants", {30'd0, mul_grant_int, mul_grant_fpu}, 32'd0);
    chk("rstw_fpu_func", {27'd0, fpu_func}, {27'd0, ALU_ADD});
    chk("rstw_req_ready", {31'd0, req_ready}, 32'd1);
    rst = 1'b0;
    stuck = 1'b0;
    ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (resp_valid) ok = 1'b0;
    end
    chk("rstw_no_response", {31'd0, ok}, 32'd1);

    do_op("post_rst_fcvt", ALU_FCVTSW, 32'd5, 32'd0, 3'd0, 32'h40A00000, 2, w);
    @(negedge clk);

    chk("grants_exclusive", both_hi, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_time_limit got=running exp=finished");
    $fatal(1, "time limit");
  end

endmodule
